// File: rtl/move_collector_pkg.sv
// Shared chess definitions for the move collector: move field layout, the
// invalid-move constant, piece/colour encodings and the collector state type.
package move_collector_pkg;

   // Move word field positions (19-bit move)
   localparam int unsigned MV_W        = 19;
   localparam int unsigned MV_INVALID  = 18;
   localparam int unsigned MV_PROMOTE  = 17;
   localparam int unsigned MV_PAWN     = 16;
   localparam int unsigned MV_PAWN2    = 15;
   localparam int unsigned MV_EP       = 14;
   localparam int unsigned MV_CASTLE   = 13;
   localparam int unsigned MV_CAPTURE  = 12;
   localparam int unsigned MV_FROM_LSB = 6;
   localparam int unsigned MV_TO_LSB   = 0;
   localparam int unsigned MV_SQ_W     = 6;

   // Empty slot filler: invalid flag set, everything else clear
   localparam logic [MV_W-1:0] IMOV = 19'h40000;

   typedef enum logic [2:0] {
      PC_NONE, PC_PAWN, PC_KNIGHT, PC_BISHOP, PC_ROOK, PC_QUEEN, PC_KING
   } piece_e;

   typedef enum logic {
      CL_WHITE, CL_BLACK
   } colour_e;

   typedef enum logic [2:0] {
      ST_IDLE, ST_WAIT, ST_CHECK, ST_LATCH, ST_EMIT, ST_NEXT, ST_FIN
   } mvc_state_e;

   function automatic logic mv_is_invalid(input logic [MV_W-1:0] mv);
      return mv[MV_INVALID];
   endfunction

endpackage

// File: rtl/move_slot_unpacker.sv
// Holds one FIFO word and walks its move slots; presents the current slot
// and whether it is an invalid (skippable) entry.
module move_slot_unpacker
   import move_collector_pkg::*;
#(
   parameter int unsigned SLOTS = 8,
   parameter int unsigned MVW   = 19
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_i,
   input  logic [SLOTS*MVW-1:0]  word_i,
   input  logic                  advance_i,
   output logic [MVW-1:0]        slot_o,
   output logic                  skip_o,
   output logic                  last_o
);

   localparam int unsigned IW = $clog2(SLOTS);

   logic [SLOTS*MVW-1:0] word_q;
   logic [IW-1:0]        idx_q;

   // Word capture on load; slot index restarts at 0 and steps on advance
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         word_q <= '0;
         idx_q  <= '0;
      end else if (load_i) begin
         word_q <= word_i;
         idx_q  <= '0;
      end else if (advance_i) begin
         idx_q  <= idx_q + IW'(1);
      end
   end

   assign slot_o = word_q[idx_q*MVW +: MVW];
   assign skip_o = mv_is_invalid(slot_o);
   assign last_o = (idx_q == IW'(SLOTS-1));

endmodule

// File: rtl/move_collector.sv
// Move collector: after start, waits for all squares done, then drains each
// square's move FIFO in order 0..NSQ-1 and streams valid moves out.
// Optional watchdog in WAIT enabled by defining MVC_TIMEOUT_EN.
module move_collector
  import move_collector_pkg::*;
#(
  parameter int unsigned NSQ     = 64,
  parameter int unsigned SLOTS   = 8,
  parameter int unsigned MVW     = 19,
  parameter int unsigned CNTW    = 9,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NSQ-1:0]           done_vec,
  output logic [$clog2(NSQ)-1:0]   sq_sel,
  output logic                     rden,
  input  logic [159:0]             fifo_q,
  input  logic                     fifo_empty,
  output logic [MVW-1:0]           mv_data,
  output logic                     mv_valid,
  input  logic                     mv_ready,
  output logic                     busy,
  output logic                     list_done,
  output logic [CNTW-1:0]          move_count
`ifdef MVC_TIMEOUT_EN
  ,
  output logic                     timeout_err
`endif
);

  localparam int unsigned SQW = $clog2(NSQ);

  mvc_state_e      state_q, state_d;
  logic [SQW-1:0]  sq_sel_q, sq_sel_d;
  logic [CNTW-1:0] count_q, count_d;

  logic           load, advance;
  logic [MVW-1:0] slot;
  logic           skip, last;
  logic           all_done;
  logic           unused_fifo_hi;

  assign all_done       = &done_vec;
  assign unused_fifo_hi = ^fifo_q[159:SLOTS*MVW];

  move_slot_unpacker #(
    .SLOTS (SLOTS),
    .MVW   (MVW)
  ) u_unpack (
    .clk_i     (clk),
    .rst_i     (reset),
    .load_i    (load),
    .word_i    (fifo_q[SLOTS*MVW-1:0]),
    .advance_i (advance),
    .slot_o    (slot),
    .skip_o    (skip),
    .last_o    (last)
  );

`ifdef MVC_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT);

  logic [TW-1:0] wait_q;
  logic          terr_q;
  logic          wait_expired;

  assign wait_expired = (state_q == ST_WAIT) && !all_done && (wait_q == TW'(TIMEOUT-1));
  assign timeout_err  = terr_q;

  // Watchdog: counts WAIT cycles; error is sticky until reset or next start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q <= '0;
      terr_q <= 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      wait_q <= '0;
      terr_q <= 1'b0;
    end else if (state_q == ST_WAIT) begin
      wait_q <= wait_q + TW'(1);
      if (wait_expired) terr_q <= 1'b1;
    end
  end
`endif

  // State, square select and move counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sq_sel_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      sq_sel_q <= sq_sel_d;
      count_q  <= count_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    sq_sel_d  = sq_sel_q;
    count_d   = count_q;
    rden      = 1'b0;
    mv_valid  = 1'b0;
    mv_data   = '0;
    list_done = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d  = '0;
          sq_sel_d = '0;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (all_done) begin
          state_d = ST_CHECK;
`ifdef MVC_TIMEOUT_EN
        end else if (wait_expired) begin
          state_d = ST_FIN;
`endif
        end
      end
      ST_CHECK: begin
        if (fifo_empty) begin
          state_d = ST_NEXT;
        end else begin
          rden    = 1'b1;
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        load    = 1'b1;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (skip) begin
          advance = 1'b1;
          if (last) state_d = ST_CHECK;
        end else begin
          mv_valid = 1'b1;
          mv_data  = slot;
          if (mv_ready) begin
            advance = 1'b1;
            if (count_q != '1) count_d = count_q + CNTW'(1);
            if (last) state_d = ST_CHECK;
          end
        end
      end
      ST_NEXT: begin
        if (sq_sel_q == SQW'(NSQ-1)) begin
          state_d = ST_FIN;
        end else begin
          sq_sel_d = sq_sel_q + SQW'(1);
          state_d  = ST_CHECK;
        end
      end
      ST_FIN: begin
        list_done = 1'b1;
        sq_sel_d  = '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sq_sel     = sq_sel_q;
  assign move_count = count_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_move_collector.sv
// Self-checking bench for move_collector: bench-side FIFO model, expected
// move list derived by scanning squares/words/slots in order.
module tb_move_collector;
  import move_collector_pkg::*;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [63:0]  done_vec;
  logic [5:0]   sq_sel;
  logic         rden;
  logic [159:0] fifo_q = '0;
  logic         fifo_empty;
  logic [18:0]  mv_data;
  logic         mv_valid, mv_ready;
  logic         busy, list_done;
  logic [8:0]   move_count;
`ifdef MVC_TIMEOUT_EN
  logic         timeout_err;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  move_collector #(.TIMEOUT(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .done_vec   (done_vec),
    .sq_sel     (sq_sel),
    .rden       (rden),
    .fifo_q     (fifo_q),
    .fifo_empty (fifo_empty),
    .mv_data    (mv_data),
    .mv_valid   (mv_valid),
    .mv_ready   (mv_ready),
    .busy       (busy),
    .list_done  (list_done),
    .move_count (move_count)
`ifdef MVC_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  // FIFO model: up to 4 words per square, 1-cycle read latency
  logic [159:0] wmem [64][4];
  int           wcnt [64];
  int           rdp  [64];
  logic         fifo_clr = 1'b0;

  assign fifo_empty = (rdp[sq_sel] >= wcnt[sq_sel]);

  always @(posedge clk) begin
    if (fifo_clr) begin
      for (int i = 0; i < 64; i++) rdp[i] <= 0;
    end else if (rden) begin
      fifo_q      <= wmem[sq_sel][rdp[sq_sel] & 3];
      rdp[sq_sel] <= rdp[sq_sel] + 1;
    end
  end

  // Reference expectations
  logic [18:0] exp_mv [$];
  int          exp_rd [$];
  int          exp_total;
  int          rmode;
  logic        prev_stall;
  logic [18:0] prev_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: monitor outputs at negedge, then drive mv_ready after posedge
  task automatic cycle();
    logic [63:0] e;
    @(negedge clk);
    if (rden === 1'b1) begin
      check("rden_nonempty", {63'd0, fifo_empty}, 64'd0);
      e = (exp_rd.size() > 0) ? 64'(exp_rd.pop_front()) : 64'hDEAD;
      check("rden_sq", 64'(sq_sel), e);
    end
    if (prev_stall) begin
      check("hold_valid", {63'd0, mv_valid}, 64'd1);
      check("hold_data", 64'(mv_data), 64'(prev_data));
    end
    if (mv_valid === 1'b1 && mv_ready === 1'b1) begin
      e = (exp_mv.size() > 0) ? 64'(exp_mv.pop_front()) : 64'hDEAD_BEEF;
      check("mv_data", 64'(mv_data), e);
    end
    prev_stall = (mv_valid === 1'b1) && (mv_ready === 1'b0);
    prev_data  = mv_data;
    @(posedge clk);
    #1;
    case (rmode)
      0:       mv_ready = 1'b1;
      1:       mv_ready = ~mv_ready;
      2:       mv_ready = 1'($urandom);
      default: mv_ready = 1'b0;
    endcase
  endtask

  task automatic clear_fifos();
    for (int s = 0; s < 64; s++) wcnt[s] = 0;
    exp_mv.delete();
    exp_rd.delete();
    fifo_clr = 1'b1;
    cycle();
    fifo_clr = 1'b0;
  endtask

  task automatic add_word(input int sq, input logic [159:0] w);
    wmem[sq][wcnt[sq]] = w;
    wcnt[sq]++;
  endtask

  // Expected output: squares ascending, words in FIFO order, valid slots in order
  task automatic build_expect();
    logic [159:0] w;
    logic [18:0]  mv;
    exp_mv.delete();
    exp_rd.delete();
    exp_total = 0;
    for (int s = 0; s < 64; s++)
      for (int k = 0; k < wcnt[s]; k++) begin
        exp_rd.push_back(s);
        w = wmem[s][k];
        for (int j = 0; j < 8; j++) begin
          mv = w[j*19 +: 19];
          if (!mv[18]) begin
            exp_mv.push_back(mv);
            exp_total++;
          end
        end
      end
  endtask

  function automatic logic [159:0] rand_word(input int density);
    logic [159:0] w;
    logic [18:0]  mv;
    w = '0;
    for (int j = 0; j < 8; j++) begin
      mv     = 19'($urandom);
      mv[18] = ($urandom_range(0, 99) >= density);
      w[j*19 +: 19] = mv;
    end
    w[159:152] = 8'($urandom);
    return w;
  endfunction

  // Word with the given valid-slot mask, random move contents
  function automatic logic [159:0] mask_word(input logic [7:0] mask);
    logic [159:0] w;
    logic [18:0]  mv;
    w = '0;
    for (int j = 0; j < 8; j++) begin
      mv     = 19'($urandom);
      mv[18] = !mask[j];
      w[j*19 +: 19] = mv;
    end
    return w;
  endfunction

  task automatic run_pass(input int bound, output int lat);
    start = 1'b1;
    cycle();
    start = 1'b0;
    lat   = 0;
    while (list_done !== 1'b1 && lat < bound) begin
      check("busy_in_pass", {63'd0, busy}, 64'd1);
      cycle();
      lat++;
    end
    check("list_done_seen", {63'd0, list_done}, 64'd1);
    check("final_count", 64'(move_count), (exp_total > 511) ? 64'd511 : 64'(exp_total));
    cycle();
    check("list_done_pulse", {63'd0, list_done}, 64'd0);
    check("idle_after", {63'd0, busy}, 64'd0);
    check("sq_sel_home", 64'(sq_sel), 64'd0);
    check("moves_left", 64'(exp_mv.size()), 64'd0);
    check("reads_left", 64'(exp_rd.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sq_sel"},   64'(sq_sel), 64'd0);
    check({tag, "_rden"},     {63'd0, rden}, 64'd0);
    check({tag, "_mv_data"},  64'(mv_data), 64'd0);
    check({tag, "_mv_valid"}, {63'd0, mv_valid}, 64'd0);
    check({tag, "_busy"},     {63'd0, busy}, 64'd0);
    check({tag, "_list_done"},{63'd0, list_done}, 64'd0);
    check({tag, "_count"},    64'(move_count), 64'd0);
`ifdef MVC_TIMEOUT_EN
    check({tag, "_terr"},     {63'd0, timeout_err}, 64'd0);
`endif
  endtask

  initial begin
    int lat;
    logic [159:0] w;
    logic [18:0]  m12;

    reset      = 1'b1;
    start      = 1'b0;
    done_vec   = '0;
    mv_ready   = 1'b0;
    rmode      = 3;
    prev_stall = 1'b0;
    prev_data  = '0;
    exp_total  = 0;
    for (int s = 0; s < 64; s++) begin wcnt[s] = 0; rdp[s] = 0; end

    clear_fifos();
    cycle();
    check_all_zero("reset");
    reset = 1'b0;
    cycle();

    // All FIFOs empty, all squares done
    rmode    = 0;
    done_vec = '1;
    clear_fifos();
    build_expect();
    run_pass(400, lat);
    check("empty_latency", 64'(lat), 64'd129);

    // Square 12: one word, only slot 0 valid
    clear_fifos();
    m12 = {7'b0010000, 6'o14, 6'o24};
    w = '0;
    for (int j = 0; j < 8; j++) w[j*19 +: 19] = IMOV;
    w[18:0] = m12;
    add_word(12, w);
    build_expect();
    run_pass(600, lat);
    check("sq12_count", 64'(move_count), 64'd1);

    // Square 0: two words of 3 valid slots, ready tied high then toggling
    for (int mode = 0; mode < 2; mode++) begin
      rmode = mode;
      clear_fifos();
      add_word(0, mask_word(8'b1000_1001));
      add_word(0, mask_word(8'b0010_0110));
      build_expect();
      run_pass(600, lat);
      check("sq0_count", 64'(move_count), 64'd6);
    end

    // Randomized passes with random backpressure
    rmode = 2;
    for (int r = 0; r < 4; r++) begin
      clear_fifos();
      for (int s = 0; s < 64; s++)
        if ($urandom_range(0, 3) == 0)
          for (int k = 0; k < int'($urandom_range(1, 3)); k++)
            add_word(s, rand_word(int'($urandom_range(0, 100))));
      build_expect();
      run_pass(8000, lat);
    end

    // Saturation: 512 valid moves, count stops at 511
    rmode = 0;
    clear_fifos();
    for (int s = 0; s < 64; s++) add_word(s, mask_word(8'hFF));
    build_expect();
    run_pass(4000, lat);
    check("sat_count", 64'(move_count), 64'd511);

    // Square 40 not done: nothing may be read while waiting
    clear_fifos();
    add_word(3, mask_word(8'b0000_0101));
    done_vec = ~(64'd1 << 40);
`ifdef MVC_TIMEOUT_EN
    start = 1'b1;
    cycle();
    start = 1'b0;
    lat = 0;
    while (list_done !== 1'b1 && lat < 100) begin
      check("to_no_rden", {63'd0, rden}, 64'd0);
      cycle();
      lat++;
    end
    check("to_latency", 64'(lat), 64'd32);
    check("to_err", {63'd0, timeout_err}, 64'd1);
    check("to_count", 64'(move_count), 64'd0);
    cycle();
    check("to_err_sticky", {63'd0, timeout_err}, 64'd1);
    check("to_idle", {63'd0, busy}, 64'd0);
    done_vec = '1;
    clear_fifos();
`else
    build_expect();
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      check("wait_no_rden", {63'd0, rden}, 64'd0);
      check("wait_busy", {63'd0, busy}, 64'd1);
      cycle();
    end
    done_vec = '1;
    lat = 0;
    while (list_done !== 1'b1 && lat < 800) begin
      cycle();
      lat++;
    end
    check("wait_done_seen", {63'd0, list_done}, 64'd1);
    check("wait_count", 64'(move_count), 64'd2);
    cycle();
    check("wait_moves_left", 64'(exp_mv.size()), 64'd0);
`endif

    // Reset mid-EMIT while a move is being offered
    rmode = 3;
    clear_fifos();
    add_word(5, mask_word(8'hFF));
    build_expect();
    start = 1'b1;
    cycle();
    start = 1'b0;
    lat = 0;
    while (mv_valid !== 1'b1 && lat < 400) begin
      cycle();
      lat++;
    end
    check("pre_reset_valid", {63'd0, mv_valid}, 64'd1);
    #2;
    reset = 1'b1;
    prev_stall = 1'b0;
    #1;
    check_all_zero("midreset");
    cycle();
    reset = 1'b0;
    cycle();

    // Fresh pass after the abort
    rmode = 2;
    clear_fifos();
    for (int s = 0; s < 64; s += 9) add_word(s, rand_word(60));
    build_expect();
    run_pass(4000, lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
